brush_plotter: RTL and testbench

BRUSH_PLOTTER -- requirements
Module: brush_plotter

---
 rtl/brush_plotter_pkg.sv | 28 ++
 rtl/brush_scan_counter.sv | 53 +++++
 rtl/brush_plotter.sv | 120 ++++++++++++
 tb/tb_brush_plotter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/brush_plotter_pkg.sv
// rtl/brush_plotter_pkg.sv - shared paint constants, state encoding and brush size decode
package brush_plotter_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOUR_W     = 3;
  localparam int SIDE_W       = 4;
  localparam int SCAN_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Brush side length in pixels for the 2-bit size select.
  function automatic logic [SIDE_W-1:0] size_to_side(input logic [1:0] size);
    logic [SIDE_W-1:0] side;
    case (size)
      2'd0:    side = 4'd1;
      2'd1:    side = 4'd2;
      2'd2:    side = 4'd4;
      default: side = 4'd8;
    endcase
    return side;
  endfunction

endpackage

// File: rtl/brush_scan_counter.sv
// rtl/brush_scan_counter.sv - row-major dx/dy scan over a side x side brush square
module brush_scan_counter
  import brush_plotter_pkg::*;
(
  input  logic              Clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              enable,
  input  logic [SIDE_W-1:0] side,
  output logic [SCAN_W-1:0] dx,
  output logic [SCAN_W-1:0] dy,
  output logic              last
);

  logic [SCAN_W-1:0] dx_q, dx_d;
  logic [SCAN_W-1:0] dy_q, dy_d;
  logic              row_end;

  // Side is never zero, so side-1 is always a valid in-square index.
  assign row_end = ({1'b0, dx_q} == (side - 4'd1));
  assign last    = row_end && ({1'b0, dy_q} == (side - 4'd1));
  assign dx      = dx_q;
  assign dy      = dy_q;

  // Next scan position: wrap dx at row end, wrap both after the final pixel.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = '0;
      dy_d = '0;
    end else if (enable) begin
      if (row_end) begin
        dx_d = '0;
        dy_d = last ? '0 : dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/brush_plotter.sv
// rtl/brush_plotter.sv - square brush stroke plotter driving a VGA adapter write port
module brush_plotter
  import brush_plotter_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                Clock,
  input  logic                resetn,
  input  logic                go,
  input  logic [7:0]          x_in,
  input  logic [6:0]          y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic [1:0]          size_in,
  input  logic                mode_in,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_e              state_q, state_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [SIDE_W-1:0]   side_q, side_d;

  logic                scan_clear;
  logic                scan_en;
  logic [SCAN_W-1:0]   dx;
  logic [SCAN_W-1:0]   dy;
  logic                scan_last;

  logic [8:0]          x_sum;
  logic [7:0]          y_sum;
  logic                in_range;
  logic                drawing;

  brush_scan_counter u_scan (
    .Clock  (Clock),
    .resetn (resetn),
    .clear  (scan_clear),
    .enable (scan_en),
    .side   (side_q),
    .dx     (dx),
    .dy     (dy),
    .last   (scan_last)
  );

  // Sums carry one extra bit so a pixel past the edge is clipped, not wrapped to column/row 0.
  assign x_sum    = {1'b0, x_q} + {6'b0, dx};
  assign y_sum    = {1'b0, y_q} + {5'b0, dy};
  assign in_range = (x_sum < X_LIM) && (y_sum < Y_LIM);
  assign drawing  = (state_q == ST_DRAW);

  assign x      = drawing ? x_sum[7:0] : 8'd0;
  assign y      = drawing ? y_sum[6:0] : 7'd0;
  assign colour = drawing ? colour_q : '0;
  assign plot   = drawing && in_range;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FINISH);

  // Stroke control: latch the request on go, scan the square, then a single finish cycle.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    side_d     = side_q;
    scan_clear = 1'b0;
    scan_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          x_d        = x_in;
          y_d        = y_in;
          colour_d   = mode_in ? '0 : colour_in;
          side_d     = size_to_side(size_in);
          scan_clear = 1'b1;
          state_d    = ST_DRAW;
        end
      end
      ST_DRAW: begin
        scan_en = 1'b1;
        if (scan_last) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched stroke parameters.
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      side_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      side_q   <= side_d;
    end
  end

endmodule

// File: tb/tb_brush_plotter.sv
// tb/tb_brush_plotter.sv - directed self-checking bench for brush_plotter
module tb_brush_plotter;

  logic       Clock;
  logic       resetn;
  logic       go;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [1:0] size_in;
  logic       mode_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  brush_plotter dut (
    .Clock     (Clock),
    .resetn    (resetn),
    .go        (go),
    .x_in      (x_in),
    .y_in      (y_in),
    .colour_in (colour_in),
    .size_in   (size_in),
    .mode_in   (mode_in),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request and pulse go for one edge; returns at the negedge of the first DRAW cycle.
  task automatic start(input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] c,
                       input logic [1:0] sz, input logic m);
    @(negedge Clock);
    resetn    = 1'b1;
    x_in      = xx;
    y_in      = yy;
    colour_in = c;
    size_in   = sz;
    mode_in   = m;
    go        = 1'b1;
    @(negedge Clock);
    go        = 1'b0;
  endtask

  // Walk a stroke cycle by cycle against the expected row-major pixel sequence.
  task automatic run_stroke(input int xx, input int yy, input int s, input logic [2:0] col,
                            input int exp_plots, input bit disturb);
    int plots;
    plots = 0;
    for (int i = 0; i < s * s; i++) begin
      int  ex;
      int  ey;
      bit  ep;
      ex = xx + (i % s);
      ey = yy + (i / s);
      ep = (ex < 160) && (ey < 120);
      check("draw_busy", 32'(busy), 32'd1);
      check("draw_done", 32'(done), 32'd0);
      check("draw_plot", 32'(plot), 32'(ep));
      if (ep) begin
        check("draw_x", 32'(x), 32'(ex));
        check("draw_y", 32'(y), 32'(ey));
        check("draw_colour", 32'(colour), 32'(col));
        plots++;
      end
      if (disturb && i == 1) begin
        go        = 1'b1;
        x_in      = 8'd99;
        y_in      = 7'd9;
        colour_in = 3'b111;
        size_in   = 2'd0;
      end
      if (disturb && i == 2) go = 1'b0;
      @(negedge Clock);
    end
    check("finish_done", 32'(done), 32'd1);
    check("finish_plot", 32'(plot), 32'd0);
    check("finish_busy", 32'(busy), 32'd1);
    check("finish_colour", 32'(colour), 32'd0);
    @(negedge Clock);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_plot", 32'(plot), 32'd0);
    check("plot_count", 32'(plots), 32'(exp_plots));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    go           = 1'b0;
    x_in         = '0;
    y_in         = '0;
    colour_in    = '0;
    size_in      = '0;
    mode_in      = 1'b0;

    // Reset state, with go held high to show reset dominates.
    go = 1'b1;
    repeat (2) @(negedge Clock);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    go = 1'b0;

    // Single pixel, go on the first edge after reset release.
    start(8'd10, 7'd20, 3'b100, 2'd0, 1'b0);
    run_stroke(10, 20, 1, 3'b100, 1, 1'b0);

    // 2x2 at origin.
    start(8'd0, 7'd0, 3'b010, 2'd1, 1'b0);
    run_stroke(0, 0, 2, 3'b010, 4, 1'b0);

    // 4x4 clipped at bottom-right corner: 3 columns x 2 rows visible.
    start(8'd157, 7'd118, 3'b011, 2'd2, 1'b0);
    run_stroke(157, 118, 4, 3'b011, 6, 1'b0);

    // 8x8 erase: colour forced to 000.
    start(8'd40, 7'd50, 3'b111, 2'd3, 1'b1);
    run_stroke(40, 50, 8, 3'b000, 64, 1'b0);

    // x at 255: sums past 255 must clip, not wrap to column 0.
    start(8'd255, 7'd119, 3'b010, 2'd1, 1'b0);
    run_stroke(255, 119, 2, 3'b010, 0, 1'b0);

    // Reset at the 10th DRAW cycle of an 8x8 stroke.
    start(8'd20, 7'd30, 3'b101, 2'd3, 1'b0);
    repeat (9) @(negedge Clock);
    check("pre_abort_plot", 32'(plot), 32'd1);
    check("pre_abort_x", 32'(x), 32'd21);
    resetn = 1'b0;
    #1;
    check("abort_plot", 32'(plot), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_x", 32'(x), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_plot", 32'(plot), 32'd0);
    end
    start(8'd5, 7'd6, 3'b110, 2'd1, 1'b0);
    run_stroke(5, 6, 2, 3'b110, 4, 1'b0);

    // Second go and changed inputs mid-stroke are ignored.
    start(8'd30, 7'd40, 3'b001, 2'd1, 1'b0);
    run_stroke(30, 40, 2, 3'b001, 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
